audio_dac_tx: RTL and testbench
===============================

# audio_dac_tx

Serializes stereo PCM samples onto the WM8731 codec's DAC data pin (AUD_DACDAT) in I2S format, with the codec acting as bit-clock and LR-clock master. It is the playback-side counterpart of the codec's ADC capture path. It sits between sample producers in the CLOCK_50 domain and the codec pins. An internal stereo-pair FIFO absorbs producer jitter. Underruns are flagged and emit silence.

## Interface
- DATA_WIDTH, 16, bits per channel sample; each codec half-frame must carry ≥ DATA_WIDTH BCLKs.
- FIFO_DEPTH, 8, stereo pairs buffered; power of two, ≥ 2.
- clk  in  1  system clock (CLOCK_50); the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = transmit from FIFO; low = drive zeros, no pops, no underrun.
- sample_valid  in  1  producer has a stereo pair.
- sample_ready  out  1  FIFO can accept a pair.
- sample_left  in  DATA_WIDTH  left sample, two's complement.
- sample_right  in  DATA_WIDTH  right sample, two's complement.
- aud_bclk  in  1  codec bit clock, asynchronous to clk.
- aud_daclrck  in  1  codec DAC LR clock; low = left, high = right.
- aud_dacdat  out  1  serial data to codec.
- underrun  out  1  one-cycle pulse: left channel started with FIFO empty while enabled.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  pairs currently buffered.

## Operation
- aud_bclk and aud_daclrck each pass through a 2-flop synchronizer.
- BCLK rising and falling edges are detected from the synchronized value as one-cycle strobes.
- On each BCLK rising strobe, synchronized LRCK is captured into lr_now and the previous value is kept in lr_prev.
- A frame edge is lr_now != lr_prev. The first rising strobe after reset only initializes lr_prev and never produces a frame edge.
- A frame edge sets pending with channel = lr_now.
- On the next BCLK falling strobe with pending set, the shift register loads. This puts the MSB on the falling edge one BCLK after the LRCK transition (I2S).
  - channel 0 (left), enable=1, FIFO non-empty: pop one pair; load left; hold right in right_hold.
  - channel 0, enable=1, FIFO empty: load zeros; right_hold = 0; pulse underrun.
  - channel 1 (right): load right_hold (zeros if enable=0).
  - enable=0: load zeros; no pop; no underrun.
- On every other BCLK falling strobe, shift left by one and fill zeros. After DATA_WIDTH bits the line stays 0 until the next load.
- aud_dacdat = shift register MSB, registered.
- FIFO push: sample_valid && sample_ready.
- sample_ready = (fifo_level < FIFO_DEPTH), computed from the registered level. When full, ready stays 0 even in a cycle that pops.
- Push and pop in the same cycle leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- enable changes take effect at the next channel load; a word in flight completes.

## Timing
- Reset values:
  - aud_dacdat=0, underrun=0, fifo_level=0, sample_ready=1.
  - Pointers, shift register, right_hold, pending, lr_prev all cleared.
- Reset mid-frame: FIFO contents are discarded and output drops to 0 at once. Transmission resumes at the first detected frame edge after a fresh lr_prev initialization.
- Pin-to-pin latency: aud_dacdat changes 4 clk cycles after a BCLK falling edge at the pin (2 sync, 1 edge detect, 1 output register). It never changes on a BCLK rising edge.
- Each BCLK high and low phase must be ≥ 3 clk periods (BCLK ≤ clk/6); DE1 48 kHz BCLK of about 3.07 MHz qualifies.
- FIFO write to readable: 1 cycle. fifo_level updates 1 cycle after a push or pop.
- underrun is high for exactly one clk cycle per empty left-channel load.

## Test plan
- Reset: hold reset_n=0 with random pin activity → aud_dacdat=0, fifo_level=0, sample_ready=1, underrun=0.
- Normal transfer: push L=16'hA5F0, R=16'h0F5A; BCLK=clk/16, 32 BCLK per channel; LRCK falls.
  - Left half-frame after one BCLK delay: 1010010111110000, then 16 zeros.
  - Right half-frame: 0000111101011010, then zeros.
  - fifo_level returns 1→0 at the left load.
- Underrun: enable=1, FIFO empty, LRCK falls → underrun pulses once, left and right half-frames all zeros, fifo_level stays 0.
- Full FIFO: with BCLK held, push 9 pairs back-to-back.
  - sample_ready drops after the 8th push; fifo_level=8; 9th pair not accepted.
  - Restart BCLK and stream 8 frames → samples 1–8 come out in order.
- Enable low: 3 pairs queued, enable=0 for 4 frames → aud_dacdat all zeros, fifo_level stays 3, no underrun. enable=1 → pair 1 sent next frame.
- Reset mid-word: assert reset_n after 5 bits of a left word → aud_dacdat=0 immediately, FIFO empty. After release, the first frame edge is ignored for initialization; data resumes cleanly afterward.

Source files
------------

// File: rtl/audio_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_tx
// Description : I2S serializer for the WM8731 DAC data pin. The codec owns
//               BCLK and DACLRCK; both are synchronized into clk. A small
//               stereo-pair FIFO absorbs producer jitter, and an empty FIFO
//               at a left-channel load produces silence plus an underrun
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  input  logic [DATA_WIDTH-1:0]           sample_left,
  input  logic [DATA_WIDTH-1:0]           sample_right,
  input  logic                            aud_bclk,
  input  logic                            aud_daclrck,
  output logic                            aud_dacdat,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Synchronizers and BCLK edge history
  logic bclk_s1_q, bclk_s1_d, bclk_s2_q, bclk_s2_d, bclk_d1_q, bclk_d1_d;
  logic lrck_s1_q, lrck_s1_d, lrck_s2_q, lrck_s2_d;
  // Frame tracking
  logic lr_prev_q, lr_prev_d, lr_init_q, lr_init_d;
  logic pending_q, pending_d, chan_q, chan_d;
  // Serializer
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, right_hold_q, right_hold_d;
  logic dacdat_q, dacdat_d, underrun_q, underrun_d;
  // FIFO bookkeeping; storage word is {left, right}
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] rd_pair;

  logic bclk_rise, bclk_fall, frame_edge, load, push, pop, fifo_empty;

  assign sample_ready = (level_q < LVL_W'(FIFO_DEPTH));
  assign fifo_level   = level_q;
  assign aud_dacdat   = dacdat_q;
  assign underrun     = underrun_q;
  assign rd_pair      = mem_q[rd_ptr_q];

  // Next-state logic for synchronizers, frame detection, serializer and FIFO
  always_comb begin
    bclk_s1_d    = aud_bclk;
    bclk_s2_d    = bclk_s1_q;
    bclk_d1_d    = bclk_s2_q;
    lrck_s1_d    = aud_daclrck;
    lrck_s2_d    = lrck_s1_q;

    bclk_rise    = bclk_s2_q & ~bclk_d1_q;
    bclk_fall    = ~bclk_s2_q & bclk_d1_q;
    push         = sample_valid & sample_ready;
    fifo_empty   = (level_q == '0);
    // The very first rising strobe only seeds lr_prev, so no edge before init.
    frame_edge   = bclk_rise & lr_init_q & (lrck_s2_q != lr_prev_q);
    load         = bclk_fall & pending_q;
    pop          = load & ~chan_q & enable & ~fifo_empty;

    lr_prev_d    = lr_prev_q;
    lr_init_d    = lr_init_q;
    pending_d    = pending_q;
    chan_d       = chan_q;
    shreg_d      = shreg_q;
    right_hold_d = right_hold_q;
    underrun_d   = 1'b0;
    dacdat_d     = shreg_q[DATA_WIDTH-1];

    if (bclk_rise) begin
      lr_prev_d = lrck_s2_q;
      lr_init_d = 1'b1;
    end
    if (frame_edge) begin
      pending_d = 1'b1;
      chan_d    = lrck_s2_q;
    end

    // Load one BCLK after the LRCK change so the MSB lands I2S-aligned.
    if (load) begin
      pending_d = 1'b0;
      if (!enable) begin
        shreg_d = '0;
      end else if (!chan_q) begin
        if (fifo_empty) begin
          shreg_d      = '0;
          right_hold_d = '0;
          underrun_d   = 1'b1;
        end else begin
          shreg_d      = rd_pair[2*DATA_WIDTH-1:DATA_WIDTH];
          right_hold_d = rd_pair[DATA_WIDTH-1:0];
        end
      end else begin
        shreg_d = right_hold_q;
      end
    end else if (bclk_fall) begin
      shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q    <= 1'b0;
      bclk_s2_q    <= 1'b0;
      bclk_d1_q    <= 1'b0;
      lrck_s1_q    <= 1'b0;
      lrck_s2_q    <= 1'b0;
      lr_prev_q    <= 1'b0;
      lr_init_q    <= 1'b0;
      pending_q    <= 1'b0;
      chan_q       <= 1'b0;
      shreg_q      <= '0;
      right_hold_q <= '0;
      dacdat_q     <= 1'b0;
      underrun_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      bclk_s1_q    <= bclk_s1_d;
      bclk_s2_q    <= bclk_s2_d;
      bclk_d1_q    <= bclk_d1_d;
      lrck_s1_q    <= lrck_s1_d;
      lrck_s2_q    <= lrck_s2_d;
      lr_prev_q    <= lr_prev_d;
      lr_init_q    <= lr_init_d;
      pending_q    <= pending_d;
      chan_q       <= chan_d;
      shreg_q      <= shreg_d;
      right_hold_q <= right_hold_d;
      dacdat_q     <= dacdat_d;
      underrun_q   <= underrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // FIFO storage; contents are don't-care until the level says otherwise
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sample_left, sample_right};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_dac_tx
// Description : Directed bench for audio_dac_tx. BCLK = clk/16, 32 BCLK per
//               channel; each captured half-frame is the 32 bits sampled late
//               in each BCLK low phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_dac_tx;

  localparam int DW = 16;
  localparam int FD = 8;
  localparam int LW = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [DW-1:0] sample_left = '0;
  logic [DW-1:0] sample_right = '0;
  logic          aud_bclk = 1'b1;
  logic          aud_daclrck = 1'b1;
  logic          aud_dacdat;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int ur_cnt = 0;

  audio_dac_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // Running count of clk cycles with underrun high
  always @(negedge clk) if (underrun === 1'b1) ur_cnt++;

  typedef struct {
    bit          push;
    logic [15:0] l;
    logic [15:0] r;
    bit          en;
    logic [15:0] el;
    logic [15:0] er;
    int          eur;
    int          epre;
    int          epost;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cwait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bclk_cycle(input logic lr, output logic smp);
    aud_bclk    = 1'b0;
    aud_daclrck = lr;
    cwait(8);
    smp         = aud_dacdat;
    aud_bclk    = 1'b1;
    cwait(8);
  endtask

  task automatic run_half(input logic lr, output logic [31:0] cap);
    logic b;
    cap = '0;
    for (int i = 0; i < 32; i++) begin
      bclk_cycle(lr, b);
      cap = {cap[30:0], b};
    end
  endtask

  task automatic run_frame(output logic [31:0] cl, output logic [31:0] cr);
    run_half(1'b0, cl);
    run_half(1'b1, cr);
  endtask

  function automatic logic [31:0] exp_half(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] cl, cr, cap;
    logic [5:0]  bits6;
    logic        b;
    int          u0;

    vecs[0] = '{1'b1, 16'hA5F0, 16'h0F5A, 1'b1, 16'hA5F0, 16'h0F5A, 0, 1, 0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1, 0, 0};
    vecs[2] = '{1'b1, 16'h8000, 16'h7FFF, 1'b1, 16'h8000, 16'h7FFF, 0, 1, 0};
    vecs[3] = '{1'b1, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 0, 1, 1};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'hFFFF, 0, 1, 0};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1, 0, 0};

    // Reset held with random pin activity
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      aud_bclk    = 1'($urandom_range(0, 1));
      aud_daclrck = 1'($urandom_range(0, 1));
    end
    chk("rst dacdat", 32'(aud_dacdat), 32'd0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("rst ready", 32'(sample_ready), 32'd1);
    chk("rst underrun", 32'(underrun), 32'd0);

    aud_bclk    = 1'b1;
    aud_daclrck = 1'b1;
    cwait(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    cwait(2);
    run_half(1'b1, cap);
    chk("idle half", cap, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      enable = vecs[i].en;
      if (vecs[i].push) push(vecs[i].l, vecs[i].r);
      chk($sformatf("v%0d level_pre", i), 32'(fifo_level), 32'(vecs[i].epre));
      u0 = ur_cnt;
      run_frame(cl, cr);
      chk($sformatf("v%0d left", i), cl, exp_half(vecs[i].el));
      chk($sformatf("v%0d right", i), cr, exp_half(vecs[i].er));
      chk($sformatf("v%0d underrun", i), 32'(ur_cnt - u0), 32'(vecs[i].eur));
      chk($sformatf("v%0d level_post", i), 32'(fifo_level), 32'(vecs[i].epost));
    end

    // Full FIFO with BCLK held high
    enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      sample_left  = 16'(32'h1000 + i);
      sample_right = 16'(32'h2000 + i);
      sample_valid = 1'b1;
      chk($sformatf("full ready_pre%0d", i), 32'(sample_ready), (i <= 8) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    chk("full level", 32'(fifo_level), 32'd8);
    chk("full ready", 32'(sample_ready), 32'd0);
    u0 = ur_cnt;
    for (int i = 1; i <= 8; i++) begin
      run_frame(cl, cr);
      chk($sformatf("full left%0d", i), cl, exp_half(16'(32'h1000 + i)));
      chk($sformatf("full right%0d", i), cr, exp_half(16'(32'h2000 + i)));
    end
    chk("full drained", 32'(fifo_level), 32'd0);
    chk("full no underrun", 32'(ur_cnt - u0), 32'd0);

    // Enable low holds the queue and emits silence
    enable = 1'b0;
    push(16'hA001, 16'hB001);
    push(16'hC3C3, 16'h3C3C);
    push(16'hFFFF, 16'hFFFF);
    chk("en level3", 32'(fifo_level), 32'd3);
    u0 = ur_cnt;
    for (int f = 0; f < 4; f++) begin
      run_frame(cl, cr);
      chk($sformatf("en0 left%0d", f), cl, 32'd0);
      chk($sformatf("en0 right%0d", f), cr, 32'd0);
    end
    chk("en0 level", 32'(fifo_level), 32'd3);
    chk("en0 underrun", 32'(ur_cnt - u0), 32'd0);
    enable = 1'b1;
    run_frame(cl, cr);
    chk("en1 left", cl, exp_half(16'hA001));
    chk("en1 right", cr, exp_half(16'hB001));
    chk("en1 level", 32'(fifo_level), 32'd2);
    run_frame(cl, cr);
    chk("en1 left2", cl, exp_half(16'hC3C3));
    chk("en1 right2", cr, exp_half(16'h3C3C));

    // Reset after 5 bits of an all-ones left word
    push(16'h1234, 16'h5678);
    chk("mid level_pre", 32'(fifo_level), 32'd2);
    bits6 = '0;
    for (int i = 0; i < 6; i++) begin
      bclk_cycle(1'b0, b);
      bits6 = {bits6[4:0], b};
    end
    chk("mid bits", 32'(bits6), 32'h1F);
    chk("mid level_pop", 32'(fifo_level), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid rst dacdat", 32'(aud_dacdat), 32'd0);
    chk("mid rst level", 32'(fifo_level), 32'd0);
    chk("mid rst ready", 32'(sample_ready), 32'd1);
    cwait(3);
    reset_n = 1'b1;
    cwait(1);
    cap = '0;
    for (int i = 6; i < 32; i++) begin
      bclk_cycle(1'b0, b);
      cap = {cap[30:0], b};
    end
    chk("post rst left rest", cap, 32'd0);
    u0 = ur_cnt;
    run_half(1'b1, cr);
    chk("post rst right", cr, 32'd0);
    chk("post rst underrun", 32'(ur_cnt - u0), 32'd0);
    push(16'hC3A5, 16'h5A3C);
    run_frame(cl, cr);
    chk("post rst left", cl, exp_half(16'hC3A5));
    chk("post rst right2", cr, exp_half(16'h5A3C));
    chk("post rst level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
